// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, constants and counter helper for the branch predictor
package bp_pkg;

    localparam int BP_XLEN      = 32;
    localparam int BP_BTB_IDX_W = 5;
    localparam int BP_TAG_W     = BP_XLEN - BP_BTB_IDX_W - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;

    typedef struct packed {
        logic                valid;
        logic                jump_bit;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
    } btb_entry_t;

    // Saturating 2-bit counter step.
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        if (taken) begin
            if (c != ST) n = ctr_t'(c + 2'd1);
        end else begin
            if (c != SNT) n = ctr_t'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB, async read, sync write, sync valid clear
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_BTB_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output btb_entry_t       rd_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  btb_entry_t       wr_entry
);

    localparam int DEPTH = 1 << IDX_W;

    btb_entry_t mem [DEPTH];

    // Read returns pre-edge contents even when the same entry is being written.
    assign rd_entry = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - gshare direction predictor with direct-mapped BTB, F lookup / E training
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN      = BP_XLEN,
    parameter int PHT_IDX_W = 8,
    parameter int GHR_W     = 8,
    parameter int BTB_IDX_W = BP_BTB_IDX_W
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [XLEN-1:0]      pc_f_i,
    output logic                 pc_src_pred_f_o,
    output logic [XLEN-1:0]      pred_target_f_o,
    output logic [PHT_IDX_W-1:0] pht_idx_f_o,
    input  logic                 valid_e_i,
    input  logic                 stall_e_i,
    input  logic                 is_branch_e_i,
    input  logic                 is_jump_e_i,
    input  logic [XLEN-1:0]      pc_e_i,
    input  logic                 pc_src_res_e_i,
    input  logic [XLEN-1:0]      pc_target_e_i,
    input  logic [PHT_IDX_W-1:0] pht_idx_e_i,
    input  logic [XLEN-1:0]      pred_target_e_i,
    output logic                 target_match_e_o
);

    localparam int PHT_SIZE = 1 << PHT_IDX_W;

    ctr_t               pht [PHT_SIZE];
    logic [GHR_W-1:0]   ghr;
    logic [GHR_W:0]     ghr_shift;
    logic               upd;
    logic               train_branch;
    logic               btb_alloc;
    logic               btb_hit;
    btb_entry_t         f_entry;
    btb_entry_t         e_entry;
    logic [PHT_IDX_W-1:0] pht_idx;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^{pc_f_i[1:0], pc_e_i[1:0]};

    assign pht_idx     = pc_f_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
    assign pht_idx_f_o = pht_idx;

    branch_target_buffer #(
        .IDX_W(BTB_IDX_W)
    ) u_btb (
        .clk      (clk_i),
        .reset    (reset_i),
        .rd_idx   (pc_f_i[BTB_IDX_W+1:2]),
        .rd_entry (f_entry),
        .wr_en    (btb_alloc),
        .wr_idx   (pc_e_i[BTB_IDX_W+1:2]),
        .wr_entry (e_entry)
    );

    // Gating with reset keeps F quiet during the reset cycle itself, before valids clear.
    assign btb_hit         = ~reset_i & f_entry.valid & (f_entry.tag == pc_f_i[XLEN-1:BTB_IDX_W+2]);
    assign pc_src_pred_f_o = btb_hit & (f_entry.jump_bit | pht[pht_idx][1]);
    assign pred_target_f_o = btb_hit ? f_entry.target : '0;

    assign upd          = valid_e_i & ~stall_e_i & ~reset_i;
    assign train_branch = upd & is_branch_e_i & ~is_jump_e_i;
    assign btb_alloc    = upd & (is_jump_e_i | (is_branch_e_i & pc_src_res_e_i));

    always_comb begin
        e_entry          = '0;
        e_entry.valid    = 1'b1;
        e_entry.jump_bit = is_jump_e_i;
        e_entry.tag      = pc_e_i[XLEN-1:BTB_IDX_W+2];
        e_entry.target   = pc_target_e_i;
    end

    // Widened shift so a single-bit history needs no special case.
    assign ghr_shift = {ghr, pc_src_res_e_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ghr <= '0;
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht[i] <= CTR_RESET;
            end
        end else if (train_branch) begin
            ghr              <= ghr_shift[GHR_W-1:0];
            pht[pht_idx_e_i] <= ctr_next(pht[pht_idx_e_i], pc_src_res_e_i);
        end
    end

    assign target_match_e_o = (pred_target_e_i == pc_target_e_i);

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and randomized checks against a table-level predictor model
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] pc_f_i;
    logic        pc_src_pred_f_o;
    logic [31:0] pred_target_f_o;
    logic [7:0]  pht_idx_f_o;
    logic        valid_e_i;
    logic        stall_e_i;
    logic        is_branch_e_i;
    logic        is_jump_e_i;
    logic [31:0] pc_e_i;
    logic        pc_src_res_e_i;
    logic [31:0] pc_target_e_i;
    logic [7:0]  pht_idx_e_i;
    logic [31:0] pred_target_e_i;
    logic        target_match_e_o;

    int errors = 0;
    int checks = 0;

    // Reference state: plain integers and arrays.
    int          m_pht [256];
    int          m_ghr;
    bit          m_v   [32];
    int unsigned m_tag [32];
    int unsigned m_tgt [32];
    bit          m_j   [32];

    branch_predictor dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .pc_f_i           (pc_f_i),
        .pc_src_pred_f_o  (pc_src_pred_f_o),
        .pred_target_f_o  (pred_target_f_o),
        .pht_idx_f_o      (pht_idx_f_o),
        .valid_e_i        (valid_e_i),
        .stall_e_i        (stall_e_i),
        .is_branch_e_i    (is_branch_e_i),
        .is_jump_e_i      (is_jump_e_i),
        .pc_e_i           (pc_e_i),
        .pc_src_res_e_i   (pc_src_res_e_i),
        .pc_target_e_i    (pc_target_e_i),
        .pht_idx_e_i      (pht_idx_e_i),
        .pred_target_e_i  (pred_target_e_i),
        .target_match_e_o (target_match_e_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        m_ghr = 0;
        for (int i = 0; i < 32; i++) m_v[i] = 1'b0;
    endtask

    task automatic model_btb_write(input int unsigned pc, input int unsigned tgt, input bit jmp);
        int bi;
        bi        = (pc / 4) % 32;
        m_v[bi]   = 1'b1;
        m_tag[bi] = pc / 128;
        m_tgt[bi] = tgt;
        m_j[bi]   = jmp;
    endtask

    task automatic model_update();
        if (reset_i) begin
            model_reset();
        end else if (valid_e_i && !stall_e_i) begin
            if (is_jump_e_i) begin
                model_btb_write(pc_e_i, pc_target_e_i, 1'b1);
            end else if (is_branch_e_i) begin
                if (pc_src_res_e_i) begin
                    if (m_pht[pht_idx_e_i] < 3) m_pht[pht_idx_e_i]++;
                    model_btb_write(pc_e_i, pc_target_e_i, 1'b0);
                end else begin
                    if (m_pht[pht_idx_e_i] > 0) m_pht[pht_idx_e_i]--;
                end
                m_ghr = ((m_ghr * 2) + int'(pc_src_res_e_i)) % 256;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_e(input bit v, input bit st, input bit br, input bit jp,
                         input int unsigned pc, input bit res, input int unsigned tgt,
                         input int unsigned idx);
        valid_e_i      = v;
        stall_e_i      = st;
        is_branch_e_i  = br;
        is_jump_e_i    = jp;
        pc_e_i         = pc;
        pc_src_res_e_i = res;
        pc_target_e_i  = tgt;
        pht_idx_e_i    = idx[7:0];
    endtask

    task automatic clear_e();
        set_e(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_f(input string tag, input int unsigned pc);
        int          idx;
        int          bi;
        bit          hit;
        logic        exp_pred;
        logic [31:0] exp_tgt;
        logic [7:0]  exp_idx;
        pc_f_i = pc;
        #1;
        idx      = ((pc / 4) % 256) ^ m_ghr;
        bi       = (pc / 4) % 32;
        hit      = !reset_i && m_v[bi] && (m_tag[bi] == pc / 128);
        exp_pred = hit && (m_j[bi] || m_pht[idx] >= 2);
        exp_tgt  = hit ? m_tgt[bi] : 32'h0;
        exp_idx  = idx[7:0];
        checks++;
        assert (pc_src_pred_f_o === exp_pred) else begin
            errors++;
            $error("FAIL %s pred: got %b expected %b", tag, pc_src_pred_f_o, exp_pred);
        end
        checks++;
        assert (pred_target_f_o === exp_tgt) else begin
            errors++;
            $error("FAIL %s target: got %h expected %h", tag, pred_target_f_o, exp_tgt);
        end
        checks++;
        assert (pht_idx_f_o === exp_idx) else begin
            errors++;
            $error("FAIL %s idx: got %h expected %h", tag, pht_idx_f_o, exp_idx);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        cycle();
        cycle();
        reset_i = 1'b0;
    endtask

    int unsigned pc_pool [6] = '{32'h40, 32'h100, 32'h104, 32'h1040, 32'h300, 32'h0};

    initial begin
        model_reset();
        reset_i = 1'b1;
        pc_f_i = 32'h0;
        pred_target_e_i = 32'h0;
        clear_e();

        // 1: reset state, including during reset
        cycle();
        check_f("during_reset", 32'h100);
        cycle();
        reset_i = 1'b0;
        check_f("after_reset", 32'h100);
        check_val("after_reset_pred_const", {31'b0, pc_src_pred_f_o}, 32'h0);

        // 2: jal allocation, then stalled jal does nothing
        set_e(1, 0, 0, 1, 32'h100, 1, 32'h200, 0);
        cycle();
        clear_e();
        check_f("jal_alloc", 32'h100);
        check_val("jal_target_const", pred_target_f_o, 32'h200);
        set_e(1, 1, 0, 1, 32'h800, 1, 32'h900, 0);
        cycle();
        clear_e();
        check_f("jal_stalled", 32'h800);
        check_val("jal_stalled_const", pred_target_f_o, 32'h0);

        // 3: counter saturation on a branch at 0x40
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_e(1, 0, 1, 0, 32'h40, 1, 32'h80, 32'h13);
            cycle();
            clear_e();
            check_f($sformatf("br_taken%0d", k), 32'h40);
        end
        check_val("br_taken_pred_const", {31'b0, pc_src_pred_f_o}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            set_e(1, 0, 1, 0, 32'h40, 0, 32'h80, 32'h13);
            cycle();
            clear_e();
            check_f($sformatf("br_nt%0d", k), 32'h40);
        end
        check_val("br_nt_target_kept", pred_target_f_o, 32'h80);

        // 4: GHR from alternating outcomes
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_e(1, 0, 1, 0, 32'h44, (k % 2) == 0, 32'h88, 0);
            cycle();
        end
        clear_e();
        check_f("ghr_idx", 32'h0);
        check_val("ghr_idx_const", {24'b0, pht_idx_f_o}, 32'hAA);

        // 5: same-cycle E write / F read of one BTB entry
        set_e(1, 0, 0, 1, 32'h300, 1, 32'h400, 0);
        cycle();
        set_e(1, 0, 0, 1, 32'h300, 1, 32'h500, 0);
        check_f("same_cycle_old", 32'h300);
        check_val("same_cycle_old_const", pred_target_f_o, 32'h400);
        cycle();
        clear_e();
        check_f("same_cycle_new", 32'h300);
        check_val("same_cycle_new_const", pred_target_f_o, 32'h500);

        // 6: update coinciding with reset is dropped
        set_e(1, 0, 0, 1, 32'h600, 1, 32'h700, 0);
        reset_i = 1'b1;
        cycle();
        reset_i = 1'b0;
        clear_e();
        check_f("reset_drop_600", 32'h600);
        check_f("reset_drop_300", 32'h300);
        check_val("reset_idx_const", {24'b0, pht_idx_f_o}, 32'hC0);
        pc_target_e_i   = 32'h200;
        pred_target_e_i = 32'h200;
        #1;
        check_val("tmatch_eq", {31'b0, target_match_e_o}, 32'h1);
        pred_target_e_i = 32'h204;
        #1;
        check_val("tmatch_ne", {31'b0, target_match_e_o}, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int unsigned tgt;
            tgt = $urandom & 32'hFFFF_FFFC;
            set_e($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  pc_pool[$urandom_range(0, 5)], $urandom_range(0, 1) == 1,
                  tgt, $urandom_range(0, 255));
            pred_target_e_i = $urandom_range(0, 1) ? tgt : ($urandom & 32'hFFFF_FFFC);
            reset_i = ($urandom_range(0, 99) == 0);
            check_f("rand", pc_pool[$urandom_range(0, 5)]);
            check_val("rand_tmatch", {31'b0, target_match_e_o},
                      {31'b0, pred_target_e_i == pc_target_e_i});
            cycle();
        end
        reset_i = 1'b0;
        clear_e();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
